sound_pwm_dac: RTL
==================

SOUND_PWM_DAC -- requirements
Module: sound_pwm_dac

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port sample_i, input, 8, unsigned audio sample from sound_generator soundOut.
REQ-004 SHALL have port sample_valid_i, input, 1, sample_i valid this cycle.
REQ-005 SHALL have port sample_ready_o, output, 1, block can accept a sample; transfer occurs on any edge with valid and ready both high.
REQ-006 SHALL have port volume_i, input, 2, volume: 3 full, 2 half, 1 quarter, 0 silent.
REQ-007 SHALL have port mute_i, input, 1, level-sensitive mute request.
REQ-008 SHALL have port pwm_o, output, 1, registered PWM audio pin.
REQ-009 SHALL have port period_done_o, output, 1, one-cycle pulse at start of each PWM period.

Function
REQ-010 SHALL run an 8-bit period counter cnt, +1 every cycle, 255 wraps to 0; period = 256 cycles; "wrap cycle" = cycle with cnt==255.
REQ-011 SHALL hold one-entry sample buffer; sample_ready_o = buffer empty (registered); accept sets buffer full, ready low next cycle.
REQ-012 SHALL on wrap cycle with buffer full: move buffer into last_sample, empty buffer, ready high next cycle; buffer empty: keep last_sample.
REQ-013 SHALL NOT forward a sample accepted on the wrap cycle into that wrap's duty; it plays from the following wrap.
REQ-014 SHALL on every wrap edge load duty = ((new last_sample >> vshift) >> att), vshift 0/1/2 for volume 3/2/1, duty 0 for volume 0; volume_i and mute_i sampled only on wrap cycle.
REQ-015 SHALL drive pwm_o(k+1) = (cnt(k) < duty(k)); duty 0 gives constant low, duty 255 gives 255 high cycles per period.
REQ-016 SHALL pulse period_done_o high exactly for the cycle where cnt==0, never otherwise.
REQ-017 SHALL run mute FSM states PLAY, RAMP_DN, MUTED, RAMP_UP with attenuation att in 0..8, updated only on wrap edges.
REQ-018 SHALL transition PLAY->RAMP_DN when mute_i=1; RAMP_DN att+1 per wrap, att==8 -> MUTED; MUTED with mute_i=0 -> RAMP_UP; RAMP_UP att-1 per wrap, att==0 -> PLAY.
REQ-019 SHALL on mute_i=0 in RAMP_DN go to RAMP_UP from current att; mute_i=1 in RAMP_UP go to RAMP_DN from current att.
REQ-020 SHALL force duty 0 in MUTED regardless of sample and volume.
REQ-021 SHALL keep accepting samples while muted (buffer cycles as normal).

Reset
REQ-022 SHALL on rst=1 at an edge set cnt=0, duty=0, last_sample=0, buffer empty, att=0, state PLAY, pwm_o=0, period_done_o=0, sample_ready_o=1.
REQ-023 SHALL treat rst mid-period identically; buffered sample discarded; counting resumes at cnt=0 on first edge after rst falls.

Configuration
REQ-024 SHALL with SOUND_PWM_SOFTMUTE_EN defined implement ramped mute per REQ-017..019.
REQ-025 SHALL without SOUND_PWM_SOFTMUTE_EN use only PLAY/MUTED: mute_i=1 on wrap -> att=8, MUTED; mute_i=0 on wrap -> att=0, PLAY.

Structure
REQ-026 SHALL place mute state enum, PWM_PERIOD=256, ATT_MAX=8 in shared package sound_pkg.
REQ-027 SHALL implement counter, duty register, comparator and period_done_o in sub-module pwm_core; handshake, scaling and FSM in top.

Verification
REQ-028 SHALL cover reset: rst high 3 cycles -> pwm_o=0, period_done_o=0, sample_ready_o=1, stays 0 output for a full period after release.
REQ-029 SHALL cover playback: sample 0x80, volume 3, after first wrap -> exactly 128 high cycles of pwm_o per 256-cycle period, period_done_o every 256 cycles.
REQ-030 SHALL cover volume: sample 0xFF, volume 1 -> 63 high cycles per period; volume 0 -> 0.
REQ-031 SHALL cover backpressure: two back-to-back valid samples 0x40,0xC0 -> first accepted, ready low until cycle after wrap, 0xC0 accepted then, duty 64 then 192 on consecutive wraps.
REQ-032 SHALL cover soft mute: sample 0x80, mute_i=1 -> duties 64,32,16,8,4,2,1,0 on successive wraps then MUTED; mute_i=0 -> duties 0,1,2,...,128 reversed; without macro duty 0 on next wrap, 128 on wrap after release.
REQ-033 SHALL cover rst asserted at cnt==100 with buffer full -> next cycle pwm_o=0, ready=1, duty 0 until a new sample plays.

Source files
------------

// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared types, constants and volume scaling for the sound PWM DAC
// Contents: mute_state_t (mute FSM states), PWM_PERIOD, ATT_MAX, counter/attenuation widths,
//           scale_sample() volume + attenuation helper.
package sound_pkg;

    localparam int PWM_PERIOD = 256;
    localparam int CNT_W      = $clog2(PWM_PERIOD);
    localparam int ATT_MAX    = 8;
    localparam int ATT_W      = 4;

    localparam logic [ATT_W-1:0] ATT_FULL = ATT_W'(ATT_MAX);

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_RAMP_DN = 2'd1,
        ST_MUTED   = 2'd2,
        ST_RAMP_UP = 2'd3
    } mute_state_t;

    // Volume 3/2/1 divides by 1/2/4, volume 0 is silent; the mute attenuation
    // is a further right shift applied after the volume step.
    function automatic logic [7:0] scale_sample(input logic [7:0]       sample,
                                                input logic [1:0]       volume,
                                                input logic [ATT_W-1:0] att);
        logic [7:0] v;
        case (volume)
            2'd3:    v = sample;
            2'd2:    v = sample >> 1;
            2'd1:    v = sample >> 2;
            default: v = 8'd0;
        endcase
        return v >> att;
    endfunction

endpackage

// File: rtl/sound_pwm_dac_if.sv
// rtl/sound_pwm_dac_if.sv - valid/ready sample stream into the sound PWM DAC
// Signals: sample_i[7:0] unsigned sample, sample_valid_i sample present,
//          sample_ready_o DAC can take a sample (transfer when both high at an edge).
// Modports: master (sample producer), slave (DAC).
interface sound_pwm_dac_if;

    logic [7:0] sample_i;
    logic       sample_valid_i;
    logic       sample_ready_o;

    modport master (
        output sample_i,
        output sample_valid_i,
        input  sample_ready_o
    );

    modport slave (
        input  sample_i,
        input  sample_valid_i,
        output sample_ready_o
    );

endinterface

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - free-running period counter, duty register, comparator and period pulse
// Ports: clk, rst (sync active-high), i_duty[7:0] duty loaded on the wrap edge,
//        o_wrap high in the cycle cnt==255, o_pwm registered PWM output,
//        o_period_done one-cycle pulse in the cycle cnt==0.
module pwm_core
    import sound_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_duty,
    output logic       o_wrap,
    output logic       o_pwm,
    output logic       o_period_done
);

    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_duty;
    logic             r_pwm;
    logic             r_period_done;
    logic             w_wrap;

    assign w_wrap        = (r_cnt == CNT_W'(PWM_PERIOD - 1));
    assign o_wrap        = w_wrap;
    assign o_pwm         = r_pwm;
    assign o_period_done = r_period_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_duty        <= 8'd0;
            r_pwm         <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_wrap) begin
                r_duty <= i_duty;
            end
            // Comparator uses the duty in force this cycle, so the new duty
            // reaches the pin starting with the cnt==0 comparison.
            r_pwm         <= (r_cnt < r_duty);
            // Registered from the wrap cycle so it lands exactly on cnt==0.
            r_period_done <= w_wrap;
        end
    end

endmodule

// File: rtl/sound_pwm_dac.sv
// rtl/sound_pwm_dac.sv - 8-bit PWM audio DAC with one-entry sample buffer, volume and mute
// Ports: clk, rst (sync active-high), bus (sound_pwm_dac_if.slave sample stream),
//        volume_i[1:0] 3 full/2 half/1 quarter/0 silent, mute_i level mute request,
//        pwm_o registered PWM pin, period_done_o pulse at the start of each PWM period.
// Build option: SOUND_PWM_SOFTMUTE_EN selects the ramped (one octave per period) mute;
//               otherwise mute switches hard between PLAY and MUTED on the wrap edge.
module sound_pwm_dac
    import sound_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    sound_pwm_dac_if.slave        bus,
    input  logic [1:0]            volume_i,
    input  logic                  mute_i,
    output logic                  pwm_o,
    output logic                  period_done_o
);

    logic [7:0]       r_buf;
    logic             r_buf_full;
    logic [7:0]       r_last;
    mute_state_t      r_state;
    logic [ATT_W-1:0] r_att;

    mute_state_t      w_state_nxt;
    logic [ATT_W-1:0] w_att_nxt;
    logic             w_accept;
    logic             w_wrap;
    logic [7:0]       w_last_nxt;
    logic [7:0]       w_duty;

    assign bus.sample_ready_o = ~r_buf_full;
    assign w_accept           = bus.sample_valid_i & ~r_buf_full;

    // Accept and drain never coincide: accepting needs an empty buffer,
    // draining needs a full one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= 8'd0;
            r_buf_full <= 1'b0;
            r_last     <= 8'd0;
        end else if (w_wrap && r_buf_full) begin
            r_last     <= r_buf;
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= bus.sample_i;
            r_buf_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PLAY;
            r_att   <= '0;
        end else if (w_wrap) begin
            r_state <= w_state_nxt;
            r_att   <= w_att_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_att_nxt   = r_att;
`ifdef SOUND_PWM_SOFTMUTE_EN
        case (r_state)
            ST_PLAY: begin
                if (mute_i) begin
                    w_state_nxt = ST_RAMP_DN;
                    w_att_nxt   = ATT_W'(1);
                end
            end
            ST_RAMP_DN: begin
                if (!mute_i) begin
                    w_state_nxt = ST_RAMP_UP;
                end else if (r_att >= ATT_FULL - 1'b1) begin
                    // Also catches a reversal entered at full attenuation.
                    w_state_nxt = ST_MUTED;
                    w_att_nxt   = ATT_FULL;
                end else begin
                    w_att_nxt = r_att + 1'b1;
                end
            end
            ST_MUTED: begin
                if (!mute_i) begin
                    w_state_nxt = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (mute_i) begin
                    w_state_nxt = ST_RAMP_DN;
                end else if (r_att <= ATT_W'(1)) begin
                    w_state_nxt = ST_PLAY;
                    w_att_nxt   = '0;
                end else begin
                    w_att_nxt = r_att - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_PLAY;
                w_att_nxt   = '0;
            end
        endcase
`else
        if (mute_i) begin
            w_state_nxt = ST_MUTED;
            w_att_nxt   = ATT_FULL;
        end else begin
            w_state_nxt = ST_PLAY;
            w_att_nxt   = '0;
        end
`endif
    end

    // Duty for the next period is built from the post-wrap sample, state and
    // attenuation; pwm_core only captures it on the wrap edge.
    assign w_last_nxt = r_buf_full ? r_buf : r_last;
    assign w_duty     = (w_state_nxt == ST_MUTED) ? 8'd0
                                                  : scale_sample(w_last_nxt, volume_i, w_att_nxt);

    pwm_core u_pwm_core (
        .clk           (clk),
        .rst           (rst),
        .i_duty        (w_duty),
        .o_wrap        (w_wrap),
        .o_pwm         (pwm_o),
        .o_period_done (period_done_o)
    );

endmodule
